// File: rtl/adder_stream_if.sv
// Purpose: handshake bundle between an operation producer, adder_stream and a result consumer.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready flow control in each direction.
// Ports: in_* = operation request, out_* = result at FIFO head, count/state = occupancy status.
interface adder_stream_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_data;
    logic             out_ovf;
    logic [CW-1:0]    count;
    logic [1:0]       state;

    // Producer/consumer side (drives requests and out_ready).
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, count, state
    );

    // Block side.
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_ovf, count, state
    );
endinterface

// File: rtl/adder_stream.sv
// Purpose: generic synchronous FIFO with occupancy count; head word reads as zero when empty.
// Latency: a word pushed on an edge is visible at the head after that edge.
// Backpressure: pushes beyond capacity (without a same-cycle pop) and pops when empty are dropped.
// Ports: clk/rst, push/push_dat write side, pop/pop_dat read side, count occupancy.
module adder_stream_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_dat,
    input  logic                       pop,
    output logic [DW-1:0]              pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty && !rst;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign do_push = push && !rst && (!full || do_pop);

    // Zeroing the head when empty keeps the output quiet after reset without resetting storage.
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so natural pointer rollover is the modulo-DEPTH wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Purpose: streaming ADD/SUB/ACC/CLR unit; every accepted operation enqueues one result+overflow flag.
// Latency: 1 cycle from acceptance edge to out_valid; results leave in acceptance order.
// Backpressure: in_ready drops when the result FIFO is full unless out_ready frees the head this cycle.
// Ports: clk, rst (async active-high), bus (adder_stream_if.slave: in_*, out_*, count, state).
module adder_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    adder_stream_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    typedef struct packed {
        logic           ovf;
        logic [WIDTH:0] dat;
    } res_t;

    logic             push;
    logic             pop;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    res_t             res_d;
    res_t             head;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH+1:0] acc_sum;
    state_t           state_q;
    state_t           state_d;

    // ---------------- handshake ----------------
    assign pop          = (cnt != '0) && bus.out_ready;
    assign bus.in_ready = !rst && ((cnt < FULL_CNT) || bus.out_ready);
    assign push         = bus.in_valid && bus.in_ready;

    // ---------------- datapath ----------------
    // One extra bit above the accumulator exposes the wrap for the ACC overflow flag.
    assign acc_sum = {1'b0, acc_q} + {2'b00, bus.in_a};

    always_comb begin
        res_d = '0;
        acc_d = acc_q;
        case (bus.in_op)
            OP_ADD: begin
                res_d.dat = {1'b0, bus.in_a} + {1'b0, bus.in_b};
            end
            OP_SUB: begin
                res_d.dat = {1'b0, bus.in_a} - {1'b0, bus.in_b};
                res_d.ovf = (bus.in_a < bus.in_b);
            end
            OP_ACC: begin
                acc_d     = acc_sum[WIDTH:0];
                res_d.dat = acc_sum[WIDTH:0];
                res_d.ovf = acc_sum[WIDTH+1];
            end
            OP_CLR: begin
                acc_d = '0;
            end
            default: begin
                res_d = '0;
            end
        endcase
    end

    // acc_d equals acc_q for ADD/SUB, so only accepted ACC/CLR move it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (push) begin
            acc_q <= acc_d;
        end
    end

    // ---------------- result FIFO ----------------
    adder_stream_fifo #(
        .DW    ($bits(res_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (res_d),
        .pop      (pop),
        .pop_dat  (head),
        .count    (cnt)
    );

    // ---------------- occupancy FSM ----------------
    // Tracks the same next count as the FIFO so state moves on the same edge as count.
    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                // DEPTH >= 2, so a single push can never fill the FIFO.
                if (push) begin
                    state_d = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (cnt_nxt == '0) begin
                    state_d = ST_EMPTY;
                end else if (cnt_nxt == FULL_CNT) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (pop && !push) begin
                    state_d = ST_PARTIAL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- outputs ----------------
    assign bus.out_valid = (cnt != '0);
    assign bus.out_data  = head.dat;
    assign bus.out_ovf   = head.ovf;
    assign bus.count     = cnt;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_adder_stream.sv
module tb_adder_stream;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << (WIDTH + 1);

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ACC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adder_stream_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    adder_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int dat;
        int ovf;
    } exp_t;

    exp_t q[$];
    int   m_acc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the operation definitions.
    function automatic exp_t model(input logic [1:0] op, input int a, input int b);
        exp_t r;
        r.dat = 0;
        r.ovf = 0;
        case (op)
            ADD: r.dat = a + b;
            SUB: begin
                r.dat = (a - b + MOD) % MOD;
                r.ovf = (a < b) ? 1 : 0;
            end
            ACC: begin
                r.ovf = (m_acc + a >= MOD) ? 1 : 0;
                m_acc = (m_acc + a) % MOD;
                r.dat = m_acc;
            end
            default: m_acc = 0;
        endcase
        return r;
    endfunction

    // Compare process: checks every cycle, then advances the model across the coming edge.
    always @(negedge clk) begin
        int n;
        bit exp_rdy;
        exp_t r;
        if (rst) begin
            q.delete();
            m_acc = 0;
            check("rst_in_ready",  bus.in_ready,  0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_count",     bus.count,     0);
            check("rst_state",     bus.state,     0);
            check("rst_out_data",  bus.out_data,  0);
            check("rst_out_ovf",   bus.out_ovf,   0);
        end else begin
            n       = q.size();
            exp_rdy = (n < DEPTH) || bus.out_ready;
            check("in_ready",  bus.in_ready,  exp_rdy);
            check("out_valid", bus.out_valid, n != 0);
            check("count",     bus.count,     n);
            check("state",     bus.state,     (n == 0) ? 0 : (n == DEPTH) ? 2 : 1);
            if (n != 0) begin
                check("out_data", bus.out_data, q[0].dat);
                check("out_ovf",  bus.out_ovf,  q[0].ovf);
                if (bus.out_ready) begin
                    void'(q.pop_front());
                end
            end
            if (bus.in_valid && exp_rdy) begin
                r = model(bus.in_op, int'(bus.in_a), int'(bus.in_b));
                q.push_back(r);
            end
        end
    end

    task automatic drive(input bit v, input logic [1:0] op, input int a, input int b, input bit ordy);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_a      = a[WIDTH-1:0];
        bus.in_b      = b[WIDTH-1:0];
        bus.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, ADD, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("init_count", bus.count, 0);
        check("init_state", bus.state, 0);
        rst = 1'b0;
        step();

        // Boundary sums/differences.
        drive(1, ADD, 255, 255, 1); step();
        check("add_255_255_data", bus.out_data, 510);
        check("add_255_255_ovf",  bus.out_ovf,  0);
        drive(1, SUB, 3, 5, 1); step();
        check("sub_3_5_data", bus.out_data, 9'h1FE);
        check("sub_3_5_ovf",  bus.out_ovf,  1);
        drive(0, ADD, 0, 0, 1); step();

        // Accumulator sequence with wrap; in_b must be ignored.
        drive(1, CLR, 9, 9, 1); step();
        check("clr_data", bus.out_data, 0);
        check("clr_ovf",  bus.out_ovf,  0);
        drive(1, ACC, 200, 17, 1); step();
        check("acc1_data", bus.out_data, 200);
        check("acc1_ovf",  bus.out_ovf,  0);
        drive(1, ACC, 200, 0, 1); step();
        check("acc2_data", bus.out_data, 400);
        check("acc2_ovf",  bus.out_ovf,  0);
        drive(1, ACC, 200, 99, 1); step();
        check("acc3_data", bus.out_data, 88);
        check("acc3_ovf",  bus.out_ovf,  1);
        drive(0, ADD, 0, 0, 1); step();

        // Fill to full, stall a fifth push, then release with simultaneous pop.
        for (int i = 1; i <= 4; i++) begin
            drive(1, ADD, i, 10 * i, 0); step();
        end
        check("full_count", bus.count, 4);
        check("full_state", bus.state, 2);
        drive(1, ADD, 50, 60, 0); #1;
        check("full_in_ready", bus.in_ready, 0);
        step();
        check("stall_count", bus.count, 4);
        check("stall_head", bus.out_data, 11);
        drive(1, ADD, 50, 60, 1); #1;
        check("full_pop_in_ready", bus.in_ready, 1);
        step();
        check("full_pushpop_count", bus.count, 4);
        check("full_pushpop_head", bus.out_data, 22);
        drive(0, ADD, 0, 0, 1);
        repeat (4) step();
        check("drain_count", bus.count, 0);
        check("drain_state", bus.state, 0);

        // Streaming at count == 1.
        drive(1, ADD, 100, 1, 1); step();
        for (int i = 0; i < 10; i++) begin
            drive(1, SUB, i, 2, 1); step();
            check("stream_count", bus.count, 1);
            check("stream_data", bus.out_data, (i - 2 + 512) % 512);
        end
        drive(0, ADD, 0, 0, 1); step();

        // Asynchronous reset mid-stream with three queued results.
        drive(1, ACC, 1, 0, 0); step();
        drive(1, ADD, 2, 0, 0); step();
        drive(1, ADD, 3, 0, 0); step();
        check("pre_rst_count", bus.count, 3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_count",     bus.count,     0);
        check("async_rst_state",     bus.state,     0);
        drive(0, ADD, 0, 0, 0);
        step();
        rst = 1'b0;
        drive(1, ACC, 7, 0, 1); step();
        check("post_rst_acc_data", bus.out_data, 7);
        check("post_rst_acc_ovf",  bus.out_ovf,  0);
        drive(0, ADD, 0, 0, 1);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
